// File: rtl/rf_rename_ckpt.sv
// ---------------------------------------------------------------------------
// rf_rename_ckpt
//   Architectural register file plus rename (dependency) table for the
//   out-of-order core. It has COMMIT_W commit ports with a same-cycle bypass
//   to the operand query. A CKPT_DEPTH-entry FIFO of rename-table snapshots
//   lets a branch mispredict restore the table without a full flush.
//
//   Optional feature: define RF_CKPT_STATS_EN to add the ckpt_stall_cnt and
//   recover_cnt statistics outputs.
//
// Ports
//   clk_in, rst_in          clock, asynchronous active-high reset
//   rdy_in                  0 freezes all state
//   flush_signal            full RoB flush (clears deps and checkpoints)
//   commit_en/reg/index/data  per-port commit; port 0 oldest
//   rs1, rs2 -> Qj/Vj, Qk/Vk  combinational operand query
//   new_entry_en, new_entry_robEntry, occupied_rd  dispatch rename
//   ckpt_take_en, ckpt_id, ckpt_full, ckpt_release_en  snapshot FIFO
//   recover_en, recover_id  restore the live table from a snapshot slot
//   ckpt_stall_cnt, recover_cnt  (RF_CKPT_STATS_EN only) saturating counters
// ---------------------------------------------------------------------------
module rf_rename_ckpt #(
    parameter  int RoB_WIDTH  = 3,
    parameter  int REG_WIDTH  = 5,
    parameter  int COMMIT_W   = 2,
    parameter  int CKPT_DEPTH = 4,
    localparam int CKPT_W     = (CKPT_DEPTH > 1) ? $clog2(CKPT_DEPTH) : 1,
    localparam int TAG_W      = RoB_WIDTH + 1
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          rdy_in,
    input  logic                          flush_signal,
    input  logic [COMMIT_W-1:0]           commit_en,
    input  logic [COMMIT_W*REG_WIDTH-1:0] commit_reg,
    input  logic [COMMIT_W*RoB_WIDTH-1:0] commit_index,
    input  logic [COMMIT_W*32-1:0]        commit_data,
    input  logic [REG_WIDTH-1:0]          rs1,
    input  logic [REG_WIDTH-1:0]          rs2,
    output logic [TAG_W-1:0]              Qj,
    output logic [TAG_W-1:0]              Qk,
    output logic [31:0]                   Vj,
    output logic [31:0]                   Vk,
    input  logic                          new_entry_en,
    input  logic [RoB_WIDTH-1:0]          new_entry_robEntry,
    input  logic [REG_WIDTH-1:0]          occupied_rd,
    input  logic                          ckpt_take_en,
    output logic [CKPT_W-1:0]             ckpt_id,
    output logic                          ckpt_full,
    input  logic                          ckpt_release_en,
    input  logic                          recover_en,
    input  logic [CKPT_W-1:0]             recover_id
`ifdef RF_CKPT_STATS_EN
    ,
    output logic [31:0]                   ckpt_stall_cnt,
    output logic [31:0]                   recover_cnt
`endif
);

    localparam int                REG_SIZE = 1 << REG_WIDTH;
    localparam int                CNT_W    = CKPT_W + 1;
    localparam logic [TAG_W-1:0]  NON_DEP  = TAG_W'(1) << RoB_WIDTH;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(CKPT_DEPTH);

    logic [31:0]       regs_q [REG_SIZE];
    logic [31:0]       regs_d [REG_SIZE];
    logic [TAG_W-1:0]  dep_q  [REG_SIZE];
    logic [TAG_W-1:0]  dep_d  [REG_SIZE];
    logic [TAG_W-1:0]  snap_q [CKPT_DEPTH][REG_SIZE];
    logic [TAG_W-1:0]  snap_d [CKPT_DEPTH][REG_SIZE];
    logic [CKPT_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic release_ok, take_ok, snap_write;

    assign ckpt_id   = tail_q;
    assign ckpt_full = (count_q == FULL_CNT);

    // A tag held by a committing RoB entry becomes NON_DEP.
    function automatic logic [TAG_W-1:0] clear_tag(input logic [TAG_W-1:0] tag);
        logic [TAG_W-1:0] res;
        res = tag;
        for (int p = 0; p < COMMIT_W; p++) begin
            if (commit_en[p] && tag == {1'b0, commit_index[p*RoB_WIDTH +: RoB_WIDTH]})
                res = NON_DEP;
        end
        return res;
    endfunction

    // Operand query. Higher ports are younger, so the last match in the
    // loop supplies the bypassed value.
    function automatic logic [TAG_W+31:0] query(input logic [REG_WIDTH-1:0] rs);
        logic [TAG_W-1:0] tag;
        logic [31:0]      val;
        logic             hit;
        tag = dep_q[rs];
        val = (dep_q[rs] == NON_DEP) ? regs_q[rs] : 32'd0;
        hit = 1'b0;
        for (int p = 0; p < COMMIT_W; p++) begin
            if (commit_en[p] && dep_q[rs] == {1'b0, commit_index[p*RoB_WIDTH +: RoB_WIDTH]}) begin
                hit = 1'b1;
                val = commit_data[p*32 +: 32];
            end
        end
        if (rs == '0 || flush_signal) begin
            tag = NON_DEP;
            val = regs_q[rs];
        end else if (hit) begin
            tag = NON_DEP;
        end
        return {tag, val};
    endfunction

    assign {Qj, Vj} = query(rs1);
    assign {Qk, Vk} = query(rs2);

    // A take is allowed when full only if a release frees a slot this cycle.
    assign release_ok = ckpt_release_en && (count_q != '0);
    assign take_ok    = ckpt_take_en && (!ckpt_full || release_ok);
    assign snap_write = take_ok && !flush_signal && !recover_en;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        regs_d  = regs_q;
        dep_d   = dep_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        // Ascending port order: the youngest writer of a register wins.
        for (int p = 0; p < COMMIT_W; p++) begin
            if (commit_en[p] && commit_reg[p*REG_WIDTH +: REG_WIDTH] != '0)
                regs_d[commit_reg[p*REG_WIDTH +: REG_WIDTH]] = commit_data[p*32 +: 32];
        end

        if (flush_signal) begin
            for (int r = 0; r < REG_SIZE; r++) dep_d[r] = NON_DEP;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (recover_en) begin
            for (int r = 0; r < REG_SIZE; r++) dep_d[r] = clear_tag(snap_q[recover_id][r]);
            // Keep slots head..recover_id, drop the younger ones.
            tail_d  = recover_id + CKPT_W'(1);
            count_d = {1'b0, CKPT_W'(recover_id - head_q)} + CNT_W'(1);
            if (release_ok) begin
                head_d  = head_q + CKPT_W'(1);
                count_d = count_d - CNT_W'(1);
            end
        end else begin
            for (int r = 0; r < REG_SIZE; r++) dep_d[r] = clear_tag(dep_q[r]);
            // Rename wins over a same-cycle commit clear of the same register.
            if (new_entry_en && occupied_rd != '0)
                dep_d[occupied_rd] = {1'b0, new_entry_robEntry};
            if (take_ok) begin
                tail_d  = tail_q + CKPT_W'(1);
                count_d = count_d + CNT_W'(1);
            end
            if (release_ok) begin
                head_d  = head_q + CKPT_W'(1);
                count_d = count_d - CNT_W'(1);
            end
        end

        dep_d[0] = NON_DEP;
    end

    // Commit clears reach every slot; invalid slots are dead data anyway.
    always_comb begin
        for (int s = 0; s < CKPT_DEPTH; s++)
            for (int r = 0; r < REG_SIZE; r++)
                snap_d[s][r] = clear_tag(snap_q[s][r]);
        if (snap_write)
            snap_d[tail_q] = dep_d;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int r = 0; r < REG_SIZE; r++) begin
                regs_q[r] <= '0;
                dep_q[r]  <= NON_DEP;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (rdy_in) begin
            regs_q  <= regs_d;
            dep_q   <= dep_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: the snapshot array has no reset; a slot is only read after a take has written it.
    always_ff @(posedge clk_in) begin
        if (rdy_in)
            snap_q <= snap_d;
    end

`ifdef RF_CKPT_STATS_EN
    logic [31:0] stall_cnt_q, rec_cnt_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            stall_cnt_q <= '0;
            rec_cnt_q   <= '0;
        end else if (rdy_in) begin
            // Both counters survive a flush and saturate.
            if (ckpt_take_en && ckpt_full && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (recover_en && !flush_signal && rec_cnt_q != '1)
                rec_cnt_q <= rec_cnt_q + 32'd1;
        end
    end

    assign ckpt_stall_cnt = stall_cnt_q;
    assign recover_cnt    = rec_cnt_q;
`endif

endmodule

// File: tb/tb_rf_rename_ckpt.sv
// ---------------------------------------------------------------------------
// tb_rf_rename_ckpt
//   Directed bench for rf_rename_ckpt with default parameters
//   (NON_DEP tag = 4'h8, 4 checkpoint slots, 2 commit ports).
// ---------------------------------------------------------------------------
module tb_rf_rename_ckpt;

    localparam logic [3:0] ND = 4'h8;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_signal;
    logic [1:0]  commit_en;
    logic [9:0]  commit_reg;
    logic [5:0]  commit_index;
    logic [63:0] commit_data;
    logic [4:0]  rs1, rs2;
    logic [3:0]  Qj, Qk;
    logic [31:0] Vj, Vk;
    logic        new_entry_en;
    logic [2:0]  new_entry_robEntry;
    logic [4:0]  occupied_rd;
    logic        ckpt_take_en, ckpt_full, ckpt_release_en, recover_en;
    logic [1:0]  ckpt_id, recover_id;
`ifdef RF_CKPT_STATS_EN
    logic [31:0] ckpt_stall_cnt, recover_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    rf_rename_ckpt dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .rdy_in             (rdy_in),
        .flush_signal       (flush_signal),
        .commit_en          (commit_en),
        .commit_reg         (commit_reg),
        .commit_index       (commit_index),
        .commit_data        (commit_data),
        .rs1                (rs1),
        .rs2                (rs2),
        .Qj                 (Qj),
        .Qk                 (Qk),
        .Vj                 (Vj),
        .Vk                 (Vk),
        .new_entry_en       (new_entry_en),
        .new_entry_robEntry (new_entry_robEntry),
        .occupied_rd        (occupied_rd),
        .ckpt_take_en       (ckpt_take_en),
        .ckpt_id            (ckpt_id),
        .ckpt_full          (ckpt_full),
        .ckpt_release_en    (ckpt_release_en),
        .recover_en         (recover_en),
        .recover_id         (recover_id)
`ifdef RF_CKPT_STATS_EN
        ,
        .ckpt_stall_cnt     (ckpt_stall_cnt),
        .recover_cnt        (recover_cnt)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        flush_signal       = 1'b0;
        commit_en          = '0;
        commit_reg         = '0;
        commit_index       = '0;
        commit_data        = '0;
        new_entry_en       = 1'b0;
        new_entry_robEntry = '0;
        occupied_rd        = '0;
        ckpt_take_en       = 1'b0;
        ckpt_release_en    = 1'b0;
        recover_en         = 1'b0;
        recover_id         = '0;
    endtask

    task automatic rename(input logic [4:0] rd, input logic [2:0] rob);
        new_entry_en       = 1'b1;
        occupied_rd        = rd;
        new_entry_robEntry = rob;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_in = 1'b1;
        rdy_in = 1'b1;
        rs1    = 5'd5;
        rs2    = 5'd0;
        idle();
        step();
        step();
        check("rst_qj", Qj, ND);
        check("rst_vj", Vj, 0);
        check("rst_ckpt_id", ckpt_id, 0);
        check("rst_full", ckpt_full, 0);
        rst_in = 1'b0;
        step();

        // 1: rename then bypass from a same-cycle commit
        rename(5'd5, 3'd3);
        step();
        idle();
        rs1 = 5'd5;
        #1;
        check("t1_qj_dep", Qj, 4'd3);
        check("t1_vj_dep", Vj, 0);
        commit_en = 2'b01; commit_reg = {5'd0, 5'd5}; commit_index = {3'd0, 3'd3};
        commit_data = {32'd0, 32'h1234};
        #1;
        check("t1_qj_byp", Qj, ND);
        check("t1_vj_byp", Vj, 32'h1234);
        step();
        idle();
        #1;
        check("t1_vj_reg", Vj, 32'h1234);

        // 2: two ports commit the same register; younger port wins
        rename(5'd7, 3'd2);
        step();
        idle();
        rs2 = 5'd7;
        commit_en = 2'b11; commit_reg = {5'd7, 5'd7}; commit_index = {3'd2, 3'd1};
        commit_data = {32'hB, 32'hA};
        #1;
        check("t2_qk_byp", Qk, ND);
        check("t2_vk_byp", Vk, 32'hB);
        step();
        idle();
        #1;
        check("t2_qk_reg", Qk, ND);
        check("t2_vk_reg", Vk, 32'hB);
        commit_en = 2'b01; commit_reg = '0; commit_index = {3'd0, 3'd5};
        commit_data = {32'd0, 32'hDEAD};
        step();
        idle();
        rs1 = 5'd0;
        #1;
        check("t2_x0_q", Qj, ND);
        check("t2_x0_v", Vj, 0);

        // 3: checkpoint then recover restores the older mapping
        rename(5'd3, 3'd4);
        step();
        idle();
        check("t3_id_before", ckpt_id, 0);
        ckpt_take_en = 1'b1;
        step();
        idle();
        rename(5'd3, 3'd6);
        step();
        idle();
        rs1 = 5'd3;
        #1;
        check("t3_qj_young", Qj, 4'd6);
        recover_en = 1'b1; recover_id = 2'd0;
        step();
        idle();
        #1;
        check("t3_qj_rec", Qj, 4'd4);
        check("t3_id_rec", ckpt_id, 1);
        ckpt_release_en = 1'b1;
        step();
        idle();
        check("t3_full", ckpt_full, 0);

        // 4: commit clears a dependency held inside a live snapshot
        rename(5'd9, 3'd2);
        ckpt_take_en = 1'b1;
        step();
        idle();
        rename(5'd9, 3'd5);
        step();
        idle();
        commit_en = 2'b01; commit_reg = {5'd0, 5'd9}; commit_index = {3'd0, 3'd2};
        commit_data = {32'd0, 32'h99};
        step();
        idle();
        rs1 = 5'd9;
        rs2 = 5'd3;
        #1;
        check("t4_qj_live", Qj, 4'd5);
        check("t4_vj_live", Vj, 0);
        recover_en = 1'b1; recover_id = 2'd1;
        step();
        idle();
        #1;
        check("t4_qj_rec", Qj, ND);
        check("t4_vj_rec", Vj, 32'h99);
        check("t4_qk_rec", Qk, 4'd4);
        check("t4_id_rec", ckpt_id, 2);

        // 5: fill the FIFO (head 1, count 1 -> 4), overflow, take+release
        ckpt_take_en = 1'b1;
        step();
        step();
        step();
        check("t5_full", ckpt_full, 1);
        check("t5_id_full", ckpt_id, 1);
        step();
        check("t5_ovf_full", ckpt_full, 1);
        check("t5_ovf_id", ckpt_id, 1);
        ckpt_release_en = 1'b1;
        step();
        check("t5_tr_full", ckpt_full, 1);
        check("t5_tr_id", ckpt_id, 2);
        ckpt_take_en = 1'b0;
        step();
        idle();
        check("t5_rel_full", ckpt_full, 0);

        // 6: flush with deps and three live checkpoints
        rename(5'd11, 3'd7);
        step();
        idle();
        rs1 = 5'd11;
        #1;
        check("t6_qj_dep", Qj, 4'd7);
        flush_signal = 1'b1;
        commit_en = 2'b01; commit_reg = {5'd0, 5'd12}; commit_index = {3'd0, 3'd0};
        commit_data = {32'd0, 32'h55};
        #1;
        check("t6_qj_flush_comb", Qj, ND);
        step();
        idle();
        #1;
        check("t6_qj", Qj, ND);
        check("t6_qk", Qk, ND);
        check("t6_full", ckpt_full, 0);
        check("t6_id", ckpt_id, 0);
        rs1 = 5'd12;
        #1;
        check("t6_commit_lands", Vj, 32'h55);

        // hold: rdy_in low freezes rename and checkpoint state
        rdy_in = 1'b0;
        rename(5'd4, 3'd1);
        ckpt_take_en = 1'b1;
        step();
        idle();
        rdy_in = 1'b1;
        rs1 = 5'd4;
        #1;
        check("hold_qj", Qj, ND);
        check("hold_id", ckpt_id, 0);

        // asynchronous reset in mid-cycle
        rename(5'd4, 3'd1);
        ckpt_take_en = 1'b1;
        step();
        idle();
        rs2 = 5'd9;
        #1;
        check("prerst_qj", Qj, 4'd1);
        check("prerst_id", ckpt_id, 1);
        rst_in = 1'b1;
        #1;
        check("arst_qj", Qj, ND);
        check("arst_id", ckpt_id, 0);
        check("arst_vk", Vk, 0);
        rst_in = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
